gol_gen_sched: RTL and testbench

Generation scheduler for the Game of Life double-buffered grid. It owns the bank-select bit that picks which of the two grid banks the video path displays. It paces the GoL engine to the display frame rate: one generation per N frames, or single-step on request. It swaps banks only during vertical blanking, so a frame never shows a half-computed generation. It also runs a clear sweep that zeroes both banks through a dedicated write port.

---
 rtl/gol_pkg.sv | 24 ++
 rtl/gol_frame_div.sv | 39 +++
 rtl/gol_gen_sched.sv | 155 +++++++++++++++
 tb/tb_gol_gen_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/gol_pkg.sv
// Shared definitions for the Game of Life generation scheduler:
// scheduler state encoding, default grid size, address-width helper
// and the bank-select polarity.
package gol_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPUTE   = 2'd1,
        WAIT_SWAP = 2'd2,
        CLEAR     = 2'd3
    } gol_sched_state_t;

    // Default grid is 256 x 256 cells
    localparam int GRID_LOG2_DEFAULT = 8;

    // disp_sel value meaning "bank A is on screen"
    localparam logic BANK_A = 1'b0;

    // Cell addresses are {y, x}, each GRID_LOG2 bits wide
    function automatic int addr_w(input int grid_log2);
        return 2 * grid_log2;
    endfunction

endpackage

// File: rtl/gol_frame_div.sv
// Frame divider: counts enabled vblanks while running and emits a
// one-cycle tick when the count reaches max(frames_per_gen, 1).
// The tick is combinational; the scheduler registers everything it drives.
module gol_frame_div (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       vblank_start,
    input  logic       run,
    input  logic [7:0] frames_per_gen,
    input  logic       clear,
    output logic       tick
);

    logic [7:0] frame_cnt;
    logic [7:0] limit;
    logic [8:0] cnt_inc;
    logic       count;

    // A zero divisor behaves as one; >= keeps a lowered divisor from stalling
    always_comb begin
        limit   = (frames_per_gen == 8'd0) ? 8'd1 : frames_per_gen;
        cnt_inc = {1'b0, frame_cnt} + 9'd1;
        count   = en & vblank_start & run;
        tick    = count & (cnt_inc >= {1'b0, limit});
    end

    // Frame counter: restarts on a tick or an end-of-clear request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
        end else if (clear || tick) begin
            frame_cnt <= 8'd0;
        end else if (count) begin
            frame_cnt <= cnt_inc[7:0];
        end
    end

endmodule

// File: rtl/gol_gen_sched.sv
// Generation scheduler for the double-buffered Game of Life grid.
// Paces the engine to the frame rate, swaps banks only in vblank and
// sweeps a clear through both banks. Define GOL_SCHED_STATS_EN to
// build the gen_count / late_count statistics counters.
module gol_gen_sched
    import gol_pkg::*;
#(
    parameter  int GRID_LOG2 = GRID_LOG2_DEFAULT,
    localparam int ADDR_W    = addr_w(GRID_LOG2)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              vblank_start,
    input  logic              run,
    input  logic [7:0]        frames_per_gen,
    input  logic              step_req,
    input  logic              clear_req,
    output logic              eng_start,
    input  logic              eng_done,
    output logic              disp_sel,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              busy,
    output logic [31:0]       gen_count,
    output logic [15:0]       late_count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    gol_sched_state_t  state, state_next;
    logic              step_pend, step_pend_next, step_take;
    logic              clr_pend, clr_pend_next, clr_take;
    logic              eng_start_next, disp_sel_next, clr_we_next;
    logic [ADDR_W-1:0] clr_addr_next;
    logic              div_en, div_clear, div_tick;
    logic              clear_last;

    assign clear_last = (state == CLEAR) && (clr_addr == ADDR_MAX);
    assign div_en     = (state == IDLE) && !clr_pend && !step_pend;
    assign div_clear  = clear_last;

    gol_frame_div u_frame_div (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (div_en),
        .vblank_start   (vblank_start),
        .run            (run),
        .frames_per_gen (frames_per_gen),
        .clear          (div_clear),
        .tick           (div_tick)
    );

    // Next-state and next-output decode; clear outranks step outranks frame tick
    always_comb begin
        state_next     = state;
        eng_start_next = 1'b0;
        disp_sel_next  = disp_sel;
        clr_we_next    = 1'b0;
        clr_addr_next  = clr_addr;
        step_take      = 1'b0;
        clr_take       = 1'b0;
        case (state)
            IDLE: begin
                if (clr_pend) begin
                    clr_take      = 1'b1;
                    clr_we_next   = 1'b1;
                    clr_addr_next = '0;
                    state_next    = CLEAR;
                end else if (step_pend) begin
                    step_take      = 1'b1;
                    eng_start_next = 1'b1;
                    state_next     = COMPUTE;
                end else if (div_tick) begin
                    eng_start_next = 1'b1;
                    state_next     = COMPUTE;
                end
            end
            COMPUTE: begin
                if (eng_done) begin
                    state_next = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (vblank_start) begin
                    disp_sel_next = ~disp_sel;
                    state_next    = IDLE;
                end
            end
            CLEAR: begin
                if (clr_addr == ADDR_MAX) begin
                    clr_addr_next = '0;
                    state_next    = IDLE;
                end else begin
                    clr_we_next   = 1'b1;
                    clr_addr_next = clr_addr + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        step_pend_next = step_req  | (step_pend & ~step_take);
        clr_pend_next  = clear_req | (clr_pend  & ~clr_take);
    end

    // State, pending flags and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            step_pend <= 1'b0;
            clr_pend  <= 1'b0;
            eng_start <= 1'b0;
            disp_sel  <= BANK_A;
            clr_we    <= 1'b0;
            clr_addr  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            step_pend <= step_pend_next;
            clr_pend  <= clr_pend_next;
            eng_start <= eng_start_next;
            disp_sel  <= disp_sel_next;
            clr_we    <= clr_we_next;
            clr_addr  <= clr_addr_next;
            busy      <= (state_next != IDLE);
        end
    end

`ifdef GOL_SCHED_STATS_EN
    logic [31:0] gen_cnt;
    logic [15:0] late_cnt;

    // Generation counter (wraps) and late-vblank counter (saturates)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gen_cnt  <= 32'd0;
            late_cnt <= 16'd0;
        end else begin
            if (clear_last) begin
                gen_cnt <= 32'd0;
            end else if ((state == WAIT_SWAP) && vblank_start) begin
                gen_cnt <= gen_cnt + 32'd1;
            end
            if ((state == COMPUTE) && vblank_start && run && (late_cnt != 16'hFFFF)) begin
                late_cnt <= late_cnt + 16'd1;
            end
        end
    end

    assign gen_count  = gen_cnt;
    assign late_count = late_cnt;
`else
    assign gen_count  = 32'd0;
    assign late_count = 16'd0;
`endif

endmodule

// File: tb/tb_gol_gen_sched.sv
// Directed self-checking bench for gol_gen_sched (GRID_LOG2 = 4).
// Inputs change 1 ns after each rising edge; outputs are checked there too.
module tb_gol_gen_sched;
    import gol_pkg::*;

`ifdef GOL_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vblank_start = 1'b0;
    logic        run = 1'b0;
    logic [7:0]  frames_per_gen = 8'd1;
    logic        step_req = 1'b0;
    logic        clear_req = 1'b0;
    logic        eng_done = 1'b0;
    logic        eng_start;
    logic        disp_sel;
    logic        clr_we;
    logic [7:0]  clr_addr;
    logic        busy;
    logic [31:0] gen_count;
    logic [15:0] late_count;

    int tests = 0;
    int failed = 0;

    gol_gen_sched #(.GRID_LOG2(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .vblank_start   (vblank_start),
        .run            (run),
        .frames_per_gen (frames_per_gen),
        .step_req       (step_req),
        .clear_req      (clear_req),
        .eng_start      (eng_start),
        .eng_done       (eng_done),
        .disp_sel       (disp_sel),
        .clr_we         (clr_we),
        .clr_addr       (clr_addr),
        .busy           (busy),
        .gen_count      (gen_count),
        .late_count     (late_count)
    );

    always #5 clk = ~clk;

    // Statistics outputs read as zero when the counters are not built
    function automatic logic [31:0] st(input int n);
        return STATS ? 32'(n) : 32'd0;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of pulse inputs, cross the edge, then drop the pulses
    task automatic applyStimulus(input logic vb, input logic sr, input logic cr, input logic ed);
        vblank_start = vb;
        step_req     = sr;
        clear_req    = cr;
        eng_done     = ed;
        @(posedge clk);
        #1;
        vblank_start = 1'b0;
        step_req     = 1'b0;
        clear_req    = 1'b0;
        eng_done     = 1'b0;
    endtask

    // One video frame: vblank, checks, optional engine completion, idle time
    task automatic runFrame(input logic exp_start, input logic exp_sel, input int exp_gen,
                            input int exp_late, input bit send_done);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("frame_eng_start", 32'(eng_start), 32'(exp_start));
        checkOutput("frame_disp_sel", 32'(disp_sel), 32'(exp_sel));
        checkOutput("frame_gen_count", gen_count, st(exp_gen));
        checkOutput("frame_late_count", 32'(late_count), st(exp_late));
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        if (send_done) applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        repeat (6) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset values
        @(posedge clk);
        #1;
        checkOutput("rst_eng_start", 32'(eng_start), 32'd0);
        checkOutput("rst_disp_sel", 32'(disp_sel), 32'(BANK_A));
        checkOutput("rst_clr_we", 32'(clr_we), 32'd0);
        checkOutput("rst_clr_addr", 32'(clr_addr), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_gen_count", gen_count, 32'd0);
        checkOutput("rst_late_count", 32'(late_count), 32'd0);
        rst_n = 1'b1;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Single step with run low; a second step requested during COMPUTE
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("step_pend_cycle", 32'(eng_start), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("step_eng_start", 32'(eng_start), 32'd1);
        checkOutput("step_busy", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("step_start_one_cycle", 32'(eng_start), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("step_no_early_swap", 32'(disp_sel), 32'd0);
        checkOutput("step_wait_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("swap1_disp_sel", 32'(disp_sel), 32'd1);
        checkOutput("swap1_gen_count", gen_count, st(1));
        checkOutput("swap1_busy", 32'(busy), 32'd0);
        checkOutput("swap1_no_start", 32'(eng_start), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("step2_eng_start", 32'(eng_start), 32'd1);

        // eng_done coincident with vblank: swap waits for the next vblank
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("coinc_no_swap", 32'(disp_sel), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("coinc_still_busy", 32'(busy), 32'd1);
        checkOutput("coinc_still_sel", 32'(disp_sel), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("coinc_swap_sel", 32'(disp_sel), 32'd0);
        checkOutput("coinc_swap_gen", gen_count, st(2));
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Free running, two frames per generation
        run = 1'b1;
        frames_per_gen = 8'd2;
        runFrame(1'b0, 1'b0, 2, 0, 1'b0);
        runFrame(1'b1, 1'b0, 2, 0, 1'b1);
        runFrame(1'b0, 1'b1, 3, 0, 1'b0);
        runFrame(1'b0, 1'b1, 3, 0, 1'b0);
        runFrame(1'b1, 1'b1, 3, 0, 1'b1);
        runFrame(1'b0, 1'b0, 4, 0, 1'b0);

        // Divisor zero acts as one; slow engine misses a vblank
        frames_per_gen = 8'd0;
        runFrame(1'b1, 1'b0, 4, 0, 1'b0);
        runFrame(1'b0, 1'b0, 4, 1, 1'b1);
        runFrame(1'b0, 1'b1, 5, 1, 1'b0);
        runFrame(1'b1, 1'b1, 5, 1, 1'b0);

        // Clear requested during COMPUTE is deferred until IDLE
        run = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("clr_deferred_we", 32'(clr_we), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_deferred_busy", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clr_pre_swap_sel", 32'(disp_sel), 32'd0);
        checkOutput("clr_pre_gen", gen_count, st(6));
        checkOutput("clr_pre_we", 32'(clr_we), 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("clr_enter_busy", 32'(busy), 32'd1);
        checkOutput("clr_enter_no_start", 32'(eng_start), 32'd0);
        for (int i = 0; i < 256; i++) begin
            checkOutput("clr_sweep_we", 32'(clr_we), 32'd1);
            checkOutput("clr_sweep_addr", 32'(clr_addr), 32'(i));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
        checkOutput("clr_done_we", 32'(clr_we), 32'd0);
        checkOutput("clr_done_busy", 32'(busy), 32'd0);
        checkOutput("clr_done_gen", gen_count, 32'd0);
        checkOutput("clr_done_sel", 32'(disp_sel), 32'd0);
        checkOutput("clr_done_late", 32'(late_count), st(1));
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("clr_after_no_start", 32'(eng_start), 32'd0);

        // Clear queued ahead of a step, then reset part way through the sweep
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rc_step_start", 32'(eng_start), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rc_swap_sel", 32'(disp_sel), 32'd1);
        checkOutput("rc_swap_gen", gen_count, st(1));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rc_clear_first_we", 32'(clr_we), 32'd1);
        checkOutput("rc_clear_first_nostart", 32'(eng_start), 32'd0);
        repeat (37) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rc_addr37", 32'(clr_addr), 32'd37);
        checkOutput("rc_sel_held", 32'(disp_sel), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rc_rst_we", 32'(clr_we), 32'd0);
        checkOutput("rc_rst_addr", 32'(clr_addr), 32'd0);
        checkOutput("rc_rst_busy", 32'(busy), 32'd0);
        checkOutput("rc_rst_sel", 32'(disp_sel), 32'd0);
        checkOutput("rc_rst_gen", gen_count, 32'd0);
        checkOutput("rc_rst_late", 32'(late_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("rc_post_no_start", 32'(eng_start), 32'd0);
            checkOutput("rc_post_no_we", 32'(clr_we), 32'd0);
            checkOutput("rc_post_idle", 32'(busy), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
